// File: rtl/mem_loader.sv
// Framed byte-stream loader: writes host payloads into IM/DM and holds the CPU
// in reset until a RUN command arrives.
module mem_loader #(
  parameter int          ADDR_W = 8,
  parameter logic [7:0]  HDR    = 8'hA5
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_valid,
  input  logic [7:0]        i_data,
  output logic              o_ready,
  output logic              o_mem_we,
  output logic              o_mem_sel,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic [7:0]        o_mem_wdata,
  output logic              o_cpu_rst_n,
  output logic              o_err,
  output logic [7:0]        o_frames
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_CMD  = 3'd1;
  localparam logic [2:0] S_ADDR = 3'd2;
  localparam logic [2:0] S_LEN  = 3'd3;
  localparam logic [2:0] S_DATA = 3'd4;
  localparam logic [2:0] S_CSUM = 3'd5;
  localparam logic [2:0] S_RUN  = 3'd6;

  logic [2:0]        r_state;
  logic              r_ready;
  logic              r_we;
  logic              r_sel;
  logic [ADDR_W-1:0] r_addr;
  logic [7:0]        r_wdata;
  logic              r_cpu_rst_n;
  logic              r_err;
  logic [7:0]        r_frames;
  logic              r_tsel;
  logic [ADDR_W-1:0] r_ptr;
  logic [8:0]        r_cnt;
  logic [7:0]        r_sum;

  logic w_acc;
  assign w_acc = i_valid & r_ready;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state     <= S_IDLE;
      r_ready     <= 1'b0;
      r_we        <= 1'b0;
      r_sel       <= 1'b0;
      r_addr      <= '0;
      r_wdata     <= 8'h00;
      r_cpu_rst_n <= 1'b0;
      r_err       <= 1'b0;
      r_frames    <= 8'h00;
      r_tsel      <= 1'b0;
      r_ptr       <= '0;
      r_cnt       <= 9'd0;
      r_sum       <= 8'h00;
    end else begin
      r_we <= 1'b0;
      // Ready is held high everywhere except RUN; the RUN entry below overrides it.
      r_ready <= (r_state != S_RUN);
      if (w_acc) begin
        case (r_state)
          S_IDLE: if (i_data == HDR) r_state <= S_CMD;
          S_CMD: begin
            if (i_data == 8'h00 || i_data == 8'h01) begin
              r_tsel  <= i_data[0];
              r_state <= S_ADDR;
            end else if (i_data == 8'h02) begin
              r_cpu_rst_n <= 1'b1;
              r_ready     <= 1'b0;
              r_state     <= S_RUN;
            end else begin
              r_err   <= 1'b1;
              r_state <= S_IDLE;
            end
          end
          S_ADDR: begin
            r_ptr   <= ADDR_W'(i_data);
            r_state <= S_LEN;
          end
          S_LEN: begin
            r_cnt   <= (i_data == 8'h00) ? 9'd256 : {1'b0, i_data};
            r_sum   <= 8'h00;
            r_state <= S_DATA;
          end
          S_DATA: begin
            r_we    <= 1'b1;
            r_sel   <= r_tsel;
            r_addr  <= r_ptr;
            r_wdata <= i_data;
            r_ptr   <= r_ptr + 1'b1;
            r_sum   <= r_sum + i_data;
            r_cnt   <= r_cnt - 9'd1;
            if (r_cnt == 9'd1) r_state <= S_CSUM;
          end
          S_CSUM: begin
            if (i_data == r_sum) r_frames <= r_frames + 8'd1;
            else                 r_err    <= 1'b1;
            r_state <= S_IDLE;
          end
          default: r_state <= S_RUN;
        endcase
      end
    end
  end

  assign o_ready     = r_ready;
  assign o_mem_we    = r_we;
  assign o_mem_sel   = r_sel;
  assign o_mem_addr  = r_addr;
  assign o_mem_wdata = r_wdata;
  assign o_cpu_rst_n = r_cpu_rst_n;
  assign o_err       = r_err;
  assign o_frames    = r_frames;

endmodule

// File: tb/tb_mem_loader.sv
// Bench for mem_loader: frame-level reference model with a write scoreboard
// checked by a strobe monitor, plus directed and randomized frames.
module tb_mem_loader;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       vld = 1'b0;
  logic [7:0] din = 8'h00;
  logic       ready, we, sel, cpu_rst_n, err;
  logic [7:0] addr, wdata, frames;

  mem_loader #(.ADDR_W(8), .HDR(8'hA5)) dut (
    .i_clk(clk), .i_rst(rst), .i_valid(vld), .i_data(din),
    .o_ready(ready), .o_mem_we(we), .o_mem_sel(sel), .o_mem_addr(addr),
    .o_mem_wdata(wdata), .o_cpu_rst_n(cpu_rst_n), .o_err(err), .o_frames(frames)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { bit sel; int addr; int data; int at; } wr_t;
  wr_t expq[$];
  int  exp_frames = 0;
  int  exp_err    = 0;
  logic [7:0] pl [0:255];

  // Every strobe must match the oldest expected write, in the cycle after its byte.
  always @(negedge clk) begin
    if (we === 1'b1) begin
      total++;
      if (expq.size() == 0) begin
        bad++;
        $display("FAIL extra_strobe got addr=%02h data=%02h want none", addr, wdata);
      end else begin
        wr_t e;
        e = expq.pop_front();
        if (sel !== e.sel || addr !== 8'(e.addr) || wdata !== 8'(e.data) || cyc != e.at) begin
          bad++;
          $display("FAIL write got sel=%0d addr=%02h data=%02h cyc=%0d want sel=%0d addr=%02h data=%02h cyc=%0d",
                   sel, addr, wdata, cyc, e.sel, e.addr, e.data, e.at);
        end
      end
    end
  end

  task automatic send_byte(input logic [7:0] b, input int gap, input bit pay, input bit s, input int a);
    total++;
    if (ready !== 1'b1) begin
      bad++;
      $display("FAIL ready_before_byte got %b want 1", ready);
    end
    vld = 1'b1;
    din = b;
    @(posedge clk);
    #1;
    if (pay) expq.push_back('{s, a % 256, int'(b), cyc});
    @(negedge clk);
    vld = 1'b0;
    repeat (gap) @(negedge clk);
  endtask

  task automatic check_status(input string tag);
    total++;
    if (frames !== 8'(exp_frames) || err !== exp_err[0] || expq.size() != 0) begin
      bad++;
      $display("FAIL %s got frames=%0d err=%b pending=%0d want frames=%0d err=%0d pending=0",
               tag, frames, err, expq.size(), exp_frames, exp_err);
    end
  endtask

  // Frame from pl[0..len-1]; model outcome is derived from the checksum rule.
  task automatic send_frame(input bit s, input int a, input int len, input bit badcs,
                            input int gfix, input int grnd, input string tag);
    int sum;
    int g;
    sum = 0;
    for (int k = 0; k < len; k++) sum += pl[k];
    sum = sum % 256;
    if (badcs) sum = (sum + 1) % 256;
    g = gfix + ((grnd > 0) ? int'($urandom_range(grnd)) : 0);
    send_byte(8'hA5, g, 0, 0, 0);
    send_byte(8'(s), g, 0, 0, 0);
    send_byte(8'(a), g, 0, 0, 0);
    send_byte(8'(len % 256), g, 0, 0, 0);
    for (int k = 0; k < len; k++) begin
      g = gfix + ((grnd > 0) ? int'($urandom_range(grnd)) : 0);
      send_byte(pl[k], g, 1, s, a + k);
    end
    send_byte(8'(sum), 0, 0, 0, 0);
    if (badcs) exp_err = 1;
    else       exp_frames = (exp_frames + 1) % 256;
    check_status(tag);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    total++;
    if (ready !== 0 || we !== 0 || sel !== 0 || addr !== 0 || wdata !== 0 ||
        cpu_rst_n !== 0 || err !== 0 || frames !== 0) begin
      bad++;
      $display("FAIL reset_values got rdy=%b we=%b sel=%b addr=%02h wd=%02h crn=%b err=%b fr=%0d want all 0",
               ready, we, sel, addr, wdata, cpu_rst_n, err, frames);
    end
    rst = 1'b0;
    #1;
    total++;
    if (ready !== 1'b0) begin bad++; $display("FAIL ready_at_release got %b want 0", ready); end
    @(negedge clk);
    total++;
    if (ready !== 1'b1) begin bad++; $display("FAIL ready_after_release got %b want 1", ready); end
  endtask

  task automatic test_write_im();
    pl[0] = 8'h13; pl[1] = 8'h05; pl[2] = 8'hA0; pl[3] = 8'h00;
    send_frame(0, 8'h00, 4, 0, 0, 0, "write_im");
  endtask

  task automatic test_wrap_gaps();
    pl[0] = 8'h11; pl[1] = 8'h22; pl[2] = 8'h33;
    send_frame(1, 8'hFE, 3, 0, 2, 0, "wrap_gaps");
  endtask

  task automatic test_len0();
    for (int k = 0; k < 256; k++) pl[k] = 8'(k);
    send_frame(1, 8'h00, 256, 0, 0, 0, "len0");
  endtask

  task automatic test_errors();
    pl[0] = 8'hAA;
    send_frame(0, 8'h10, 1, 1, 0, 0, "bad_csum");
    send_byte(8'hA5, 0, 0, 0, 0);
    send_byte(8'h07, 0, 0, 0, 0);
    exp_err = 1;
    check_status("bad_cmd");
    pl[0] = 8'h5A; pl[1] = 8'hC3;
    send_frame(1, 8'h40, 2, 0, 0, 0, "good_after_err");
  endtask

  task automatic test_random();
    for (int f = 0; f < 12; f++) begin
      int n;
      n = $urandom_range(3);
      for (int k = 0; k < n; k++) begin
        logic [7:0] b;
        b = 8'($urandom);
        if (b == 8'hA5 || b == 8'h00) b = 8'h3C;
        send_byte(b, $urandom_range(1), 0, 0, 0);
      end
      n = $urandom_range(1, 24);
      for (int k = 0; k < n; k++) pl[k] = 8'($urandom);
      send_frame($urandom_range(1), $urandom_range(255), n, ($urandom_range(4) == 0),
                 0, 2, "random_frame");
    end
  endtask

  task automatic test_reset_mid();
    pl[0] = 8'h01; pl[1] = 8'h02; pl[2] = 8'h03; pl[3] = 8'h04;
    send_byte(8'hA5, 0, 0, 0, 0);
    send_byte(8'h00, 0, 0, 0, 0);
    send_byte(8'h20, 0, 0, 0, 0);
    send_byte(8'h04, 0, 0, 0, 0);
    send_byte(pl[0], 0, 1, 0, 8'h20);
    send_byte(pl[1], 0, 1, 0, 8'h21);
    rst = 1'b1; vld = 1'b1; din = pl[2];
    @(negedge clk);
    exp_frames = 0; exp_err = 0;
    total++;
    if (we !== 0 || ready !== 0 || frames !== 0 || err !== 0 || expq.size() != 0) begin
      bad++;
      $display("FAIL reset_mid got we=%b rdy=%b fr=%0d err=%b pending=%0d want 0 0 0 0 0",
               we, ready, frames, err, expq.size());
    end
    vld = 1'b0; rst = 1'b0;
    @(negedge clk);
    total++;
    if (ready !== 1'b1) begin bad++; $display("FAIL ready_after_mid_reset got %b want 1", ready); end
    send_frame(0, 8'h20, 4, 0, 0, 0, "replay");
  endtask

  task automatic test_run();
    send_byte(8'h3C, 0, 0, 0, 0);
    send_byte(8'hA5, 0, 0, 0, 0);
    total++;
    if (cpu_rst_n !== 1'b0) begin bad++; $display("FAIL cpu_rst_before_run got %b want 0", cpu_rst_n); end
    send_byte(8'h02, 0, 0, 0, 0);
    total++;
    if (cpu_rst_n !== 1'b1 || ready !== 1'b0) begin
      bad++;
      $display("FAIL run_entry got crn=%b rdy=%b want crn=1 rdy=0", cpu_rst_n, ready);
    end
    pl[0] = 8'hA5; pl[1] = 8'h00; pl[2] = 8'h00; pl[3] = 8'h01; pl[4] = 8'h77; pl[5] = 8'h77;
    for (int k = 0; k < 12; k++) begin
      vld = 1'b1; din = pl[k % 6];
      @(negedge clk);
    end
    vld = 1'b0;
    total++;
    if (cpu_rst_n !== 1'b1 || ready !== 1'b0 || frames !== 8'(exp_frames)) begin
      bad++;
      $display("FAIL run_hold got crn=%b rdy=%b fr=%0d want crn=1 rdy=0 fr=%0d",
               cpu_rst_n, ready, frames, exp_frames);
    end
    rst = 1'b1;
    @(negedge clk);
    total++;
    if (cpu_rst_n !== 1'b0 || ready !== 1'b0) begin
      bad++;
      $display("FAIL reset_in_run got crn=%b rdy=%b want crn=0 rdy=0", cpu_rst_n, ready);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_write_im();
    test_wrap_gaps();
    test_len0();
    test_errors();
    test_random();
    test_reset_mid();
    test_run();
    total++;
    if (expq.size() != 0) begin
      bad++;
      $display("FAIL missing_strobes got pending=%0d want 0", expq.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_loader.md
# mem_loader

Byte-stream program/data loader for the single-cycle processor. It accepts framed bytes from a host link and writes them into the byte-wide instruction memory (IM) or data memory (DM). It holds the CPU in reset until a RUN command is received. It is the write-side counterpart to the memory/register dump performed at the end of simulation.

## Interface
Parameters:
- ADDR_W, 8, memory byte-address width (256-byte memories).
- HDR, 8'hA5, frame header byte.

Ports:
- i_clk  input  1  clock; all logic on the rising edge.
- i_rst  input  1  reset, synchronous, active-high.
- i_valid  input  1  host byte valid.
- i_data  input  8  host byte.
- o_ready  output  1  loader can accept a byte; a transfer occurs on an edge with i_valid & o_ready.
- o_mem_we  output  1  one-cycle memory write strobe.
- o_mem_sel  output  1  target of the write: 0 = IM, 1 = DM.
- o_mem_addr  output  ADDR_W  write byte address.
- o_mem_wdata  output  8  write byte.
- o_cpu_rst_n  output  1  CPU reset, active-low; 0 until RUN.
- o_err  output  1  sticky error flag.
- o_frames  output  8  count of good write frames; wraps at 255 -> 0.

## Operation
- Frame format: HDR, CMD, then for CMD 0x00 (write IM) or 0x01 (write DM): ADDR, LEN, LEN payload bytes, CSUM.
  - LEN = 0 means 256 bytes.
  - CSUM = 8-bit sum of the payload bytes, mod 256.
- CMD 0x02 (RUN) has no further bytes.
- State machine: IDLE, CMD, ADDR, LEN, DATA, CSUM, RUN.
  - IDLE: an accepted byte == HDR -> CMD; any other byte is discarded, stay in IDLE.
  - CMD:
    - 0x00/0x01: latch sel -> ADDR.
    - 0x02 -> RUN.
    - Any other value: set o_err -> IDLE.
  - ADDR: latch base address -> LEN.
  - LEN: latch count (0 -> 256, 9-bit counter), clear running sum -> DATA.
  - DATA: each accepted byte k (k = 0..count-1) is written to address (base + k) mod 256, and the byte is added to the running sum. After the last byte -> CSUM.
  - CSUM:
    - Byte == running sum: increment o_frames.
    - Otherwise: set o_err.
    - Either way -> IDLE.
    - Payload writes are not rolled back on mismatch.
  - RUN: terminal. o_cpu_rst_n = 1, o_ready = 0. Only i_rst exits RUN.
- Address wrap: base 0xFE, LEN 3 writes 0xFE, 0xFF, 0x00.
- o_err is cleared only by i_rst.
- Bytes are consumed only on an accepted transfer; gaps in i_valid stall the FSM in its current state with no side effects.

## Timing
- Reset values: state IDLE, o_ready 0, o_mem_we 0, o_mem_sel 0, o_mem_addr 0, o_mem_wdata 0, o_cpu_rst_n 0, o_err 0, o_frames 0.
- o_ready:
  - Registered.
  - Goes 1 on the first edge after i_rst falls.
  - Stays 1 in every state except RUN.
  - Goes 0 on the same edge that enters RUN.
- Write latency: a payload byte accepted at edge n causes o_mem_we = 1 with the matching addr/wdata/sel during cycle n+1 (registered), for exactly one cycle.
  - Back-to-back payload bytes produce back-to-back write strobes, one per cycle.
- o_cpu_rst_n rises on the edge that accepts CMD 0x02.
- o_err and o_frames update on the edge that accepts the offending or closing byte.
- i_rst asserted mid-frame:
  - On that edge: the FSM returns to IDLE, o_mem_we is forced to 0 with no partial write issued, and all outputs take their reset values, including o_cpu_rst_n = 0 when in RUN.
  - A frame interrupted by reset is lost; the host must resend from HDR.
- Sustained throughput: one byte per cycle; a LEN = N frame takes N+5 accepted bytes.

## Test plan
- Write IM: A5 00 00 04 13 05 A0 00 B8 with valid held continuously -> 4 strobes, sel 0, at addr 00..03 with data 13, 05, A0, 00, one per cycle starting the cycle after each byte; o_frames = 1, o_err = 0.
- Wrap and gaps: A5 01 FE 03 11 22 33 66 with i_valid deasserted for 2 cycles between bytes -> DM writes at FE=11, FF=22, 00=33; no extra strobes during gaps; o_frames increments.
- LEN = 0: A5 01 00 00, then 256 bytes of value i, then CSUM 80 -> 256 strobes, addr i = data i; o_frames = 1.
- Errors:
  - A5 00 10 01 AA 00 -> write at 10 = AA still issued, o_err = 1, o_frames unchanged.
  - A5 07 -> o_err = 1, no strobes.
  - A subsequent valid frame still loads correctly with o_err remaining 1.
- RUN: stray 3C byte, then A5 02 -> 3C ignored; o_cpu_rst_n = 1 and o_ready = 0 from the edge accepting 02; later bytes have no effect.
- Reset mid-operation:
  - i_rst asserted during DATA after 2 of 4 bytes -> no further strobes, state IDLE, o_ready 0 during reset, 1 on the edge after release; replaying the full frame succeeds.
  - i_rst asserted in RUN -> o_cpu_rst_n returns to 0.
